lte_dw_dfe_xant_deframer: RTL and testbench
===========================================

Name: lte_dw_dfe_xant_deframer

Overview:
- Downstream neighbour of the DFE x8 transfer interface, in the 491.52 MHz domain.
- Consumes its serial 16-bit I/Q word stream, which is framed by a frame pulse and a per-antenna-group end marker.
- Checks the stream's framing, re-pairs I/Q words into 32-bit samples, tags each with an antenna index, and flags framing errors to the control plane.
- Feeds the per-antenna DFE carrier paths.

Parameters:
- NUM_ANT, 8, antenna groups per frame.
- CNT_W, 16, width of the framing-error counter.

Ports:
- sys_clk_491p52  input  1  block clock.
- sys_rst_491p52  input  1  asynchronous reset, active-high.
- i_mod_sel  input  2  bandwidth select: 1 = 10M, 2 = 15M, 3 = 20M, 0 = 20M.
- i_fram  input  1  high on word 0 of a frame.
- i_xant  input  1  high on the last word of each antenna group.
- i_data  input  16  word stream; even word = I, odd word = Q.
- o_vld  output  1  output sample valid.
- o_sof  output  1  first sample of antenna 0 of a frame; only with o_vld.
- o_ant_idx  output  3  antenna index of the sample (0..NUM_ANT-1).
- o_iq  output  32  I in [31:16], Q in [15:0].
- o_locked  output  1  framing locked.
- o_err_pulse  output  1  one-cycle pulse per framing error.
- o_err_cnt  output  CNT_W  saturating framing-error count.

Behaviour:
- Reset: all outputs 0; FSM in HUNT; all counters 0.
- Group length G (words):
  - 32 when mod_sel is 1 or 2.
  - 16 when mod_sel is 3 or 0.
  - mod_sel is sampled only on a cycle with i_fram=1; that value is held for the whole frame.
- Counters:
  - word counter wc, 0..G-1.
  - antenna counter ac, 0..NUM_ANT-1.
  - An I/Q phase bit, phase = wc[0].
- FSM states: HUNT, RUN.
- HUNT:
  - Ignores data and i_xant.
  - On i_fram: wc=1, ac=0, capture i_data as I, latch G; next state RUN.
  - o_locked=0.
- RUN, per input cycle:
  - phase 0: capture i_data as I.
  - phase 1: register {I, i_data}, o_ant_idx=ac, o_vld=1 on the next cycle.
  - Latency: Q word in -> o_vld out = 1 cycle.
  - o_sof=1 on the output of the wc=1, ac=0 pair.
  - o_locked=1 while in RUN.
- End of group (wc=G-1):
  - i_xant is required high.
  - wc wraps to 0; ac increments.
  - After ac=NUM_ANT-1, ac wraps to 0 and i_fram is required on the following cycle.
- Error conditions, each giving o_err_pulse=1 for 1 cycle and a return to HUNT:
  - i_xant=1 with wc != G-1.
  - i_xant=0 with wc == G-1.
  - i_fram=0 on the cycle after the last word of a frame.
  - i_fram=1 with wc != 0 or ac != 0, i.e. mid-frame.
- Recovery:
  - A mid-frame i_fram error re-acquires on that same cycle: treated as a HUNT i_fram, so RUN is re-entered with wc=1, ac=0.
  - The other errors leave HUNT on the next i_fram.
- On any error, the partially paired sample is discarded; o_vld is not asserted for it.
- Simultaneous i_fram and i_xant on a valid group-end/frame-start boundary never coincide (they fall on different cycles); i_fram=1 together with i_xant=1 counts as one error, not two.
- Reset asserted mid-frame: immediate return to reset values; no output on the cycle reset releases.
- o_ant_idx: 3 bits wide, upper bits 0 when NUM_ANT<8.

Optional Feature:
- Macro: LTE_DW_DFE_DEFRAMER_STAT_EN.
- Defined:
  - o_err_cnt increments by 1 on each o_err_pulse and saturates at all-ones.
  - Reset by reset only.
- Undefined:
  - o_err_cnt is tied to 0 and its counter logic is absent.
  - o_err_pulse is unaffected.

Test Plan:
- 20M case:
  - Stimulus: reset; mod_sel=3; i_fram; 8 groups of 16 words with i_xant on word 15; data = ramp 0,1,2,…
  - Required: 64 o_vld; first o_iq=0x00000001 with o_sof=1, ant_idx=0; o_iq=0x00100011 with ant_idx=1; o_locked=1; no error.
- 10M case:
  - Stimulus: same as above with mod_sel=1, G=32, over 3 back-to-back frames.
  - Required: 128 o_vld per frame; ant_idx steps every 16 samples; o_sof once per frame; o_err_cnt=0.
- Early xant:
  - Stimulus: i_xant asserted on word 9 of group 2.
  - Required: o_err_pulse one cycle later; o_locked=0; no o_vld until the next i_fram; o_err_cnt=1 with the macro, 0 without.
- Mid-frame re-sync:
  - Stimulus: i_fram arrives at group 4, word 6.
  - Required: one error; the next output pair carries o_sof=1, ant_idx=0, o_iq built from the new words 0/1; o_locked is high again the next cycle.
- Missing frame pulse, then reset:
  - Stimulus: no i_fram after the last word of a frame; later, a reset pulse mid-frame.
  - Required: error, then HUNT. After the reset all outputs are 0, and re-acquisition happens on the next i_fram.
- Saturation (macro defined, CNT_W=4):
  - Stimulus: force 20 errors.
  - Required: o_err_cnt holds at 15.

Source files
------------

// File: rtl/lte_dw_dfe_xant_deframer_if.sv
// rtl/lte_dw_dfe_xant_deframer_if.sv - word-stream input and tagged-sample output bundle of the x-ant deframer
interface lte_dw_dfe_xant_deframer_if #(
  parameter int CNT_W = 16
);
  logic [1:0]       i_mod_sel;
  logic             i_fram;
  logic             i_xant;
  logic [15:0]      i_data;
  logic             o_vld;
  logic             o_sof;
  logic [2:0]       o_ant_idx;
  logic [31:0]      o_iq;
  logic             o_locked;
  logic             o_err_pulse;
  logic [CNT_W-1:0] o_err_cnt;

  modport master (
    output i_mod_sel, i_fram, i_xant, i_data,
    input  o_vld, o_sof, o_ant_idx, o_iq, o_locked, o_err_pulse, o_err_cnt
  );

  modport slave (
    input  i_mod_sel, i_fram, i_xant, i_data,
    output o_vld, o_sof, o_ant_idx, o_iq, o_locked, o_err_pulse, o_err_cnt
  );
endinterface

// File: rtl/lte_dw_dfe_xant_deframer.sv
// rtl/lte_dw_dfe_xant_deframer.sv - x-ant word-stream deframer: framing check, I/Q pairing, antenna tagging
// Optional saturating framing-error counter enabled by LTE_DW_DFE_DEFRAMER_STAT_EN.
module lte_dw_dfe_xant_deframer #(
  parameter int NUM_ANT = 8,
  parameter int CNT_W   = 16
) (
  input  logic                          sys_clk_491p52,
  input  logic                          sys_rst_491p52,
  lte_dw_dfe_xant_deframer_if.slave     bus
);

  typedef enum logic {HUNT, RUN} state_t;

  localparam logic [2:0] AC_LAST = 3'(NUM_ANT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  wc;
  logic [2:0]  ac;
  logic        g_long;
  logic [15:0] i_word;
  logic        vld;
  logic        sof;
  logic [2:0]  ant_idx;
  logic [31:0] iq;
  logic        err_pulse;

  logic [4:0]  wc_last;
  logic        at_frame_start;
  logic        at_group_end;
  logic        acquire;
  logic        err_det;
  logic        pair_out;

  assign wc_last        = g_long ? 5'd31 : 5'd15;
  assign at_frame_start = (wc == 5'd0) && (ac == 3'd0);
  assign at_group_end   = (wc == wc_last);

  always_ff @(posedge sys_clk_491p52 or posedge sys_rst_491p52) begin
    if (sys_rst_491p52) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  // A frame pulse where none is expected is an error but also a valid new frame start.
  always_comb begin
    state_nxt = state;
    acquire   = 1'b0;
    err_det   = 1'b0;
    pair_out  = 1'b0;
    case (state)
      HUNT: begin
        if (bus.i_fram) begin
          acquire   = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (at_frame_start) begin
          if (!bus.i_fram || bus.i_xant) begin
            err_det   = 1'b1;
            state_nxt = HUNT;
          end else begin
            acquire = 1'b1;
          end
        end else if (bus.i_fram) begin
          err_det = 1'b1;
          acquire = 1'b1;
        end else if (bus.i_xant != at_group_end) begin
          err_det   = 1'b1;
          state_nxt = HUNT;
        end else begin
          pair_out = wc[0];
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  always_ff @(posedge sys_clk_491p52 or posedge sys_rst_491p52) begin
    if (sys_rst_491p52) begin
      wc        <= 5'd0;
      ac        <= 3'd0;
      g_long    <= 1'b0;
      i_word    <= 16'd0;
      vld       <= 1'b0;
      sof       <= 1'b0;
      ant_idx   <= 3'd0;
      iq        <= 32'd0;
      err_pulse <= 1'b0;
    end else begin
      vld       <= 1'b0;
      sof       <= 1'b0;
      err_pulse <= err_det;
      if (acquire) begin
        wc     <= 5'd1;
        ac     <= 3'd0;
        i_word <= bus.i_data;
        g_long <= (bus.i_mod_sel == 2'd1) || (bus.i_mod_sel == 2'd2);
      end else if ((state == RUN) && !err_det) begin
        if (!wc[0]) begin
          i_word <= bus.i_data;
        end
        if (pair_out) begin
          vld     <= 1'b1;
          sof     <= (wc == 5'd1) && (ac == 3'd0);
          iq      <= {i_word, bus.i_data};
          ant_idx <= ac;
        end
        if (at_group_end) begin
          wc <= 5'd0;
          ac <= (ac == AC_LAST) ? 3'd0 : ac + 3'd1;
        end else begin
          wc <= wc + 5'd1;
        end
      end
    end
  end

  assign bus.o_vld       = vld;
  assign bus.o_sof       = sof;
  assign bus.o_ant_idx   = ant_idx;
  assign bus.o_iq        = iq;
  assign bus.o_locked    = (state == RUN);
  assign bus.o_err_pulse = err_pulse;

`ifdef LTE_DW_DFE_DEFRAMER_STAT_EN
  logic [CNT_W-1:0] err_cnt;

  always_ff @(posedge sys_clk_491p52 or posedge sys_rst_491p52) begin
    if (sys_rst_491p52) begin
      err_cnt <= '0;
    end else if (err_det && (err_cnt != {CNT_W{1'b1}})) begin
      err_cnt <= err_cnt + CNT_W'(1);
    end
  end

  assign bus.o_err_cnt = err_cnt;
`else
  assign bus.o_err_cnt = '0;
`endif

endmodule

// File: tb/tb_lte_dw_dfe_xant_deframer.sv
// tb/tb_lte_dw_dfe_xant_deframer.sv - self-checking bench for the x-ant deframer
`timescale 1ns/1ps
module tb_lte_dw_dfe_xant_deframer;

  localparam int CNT_W = 4;

  typedef struct {
    logic [31:0] iq;
    logic [2:0]  ant;
    logic        sof;
  } exp_t;

  typedef struct {
    logic [1:0]  ms;
    logic [15:0] base;
    int          n_vld;
    logic [31:0] first_iq;
    logic [31:0] ant1_iq;
  } vec_t;

  logic sys_clk_491p52 = 1'b0;
  logic sys_rst_491p52 = 1'b1;

  lte_dw_dfe_xant_deframer_if #(.CNT_W(CNT_W)) bus ();

  lte_dw_dfe_xant_deframer #(.NUM_ANT(8), .CNT_W(CNT_W)) dut (
    .sys_clk_491p52 (sys_clk_491p52),
    .sys_rst_491p52 (sys_rst_491p52),
    .bus            (bus)
  );

  always #2 sys_clk_491p52 = ~sys_clk_491p52;

  int          total = 0;
  int          bad = 0;
  int          vld_seen = 0;
  int          sof_seen = 0;
  int          err_seen = 0;
  int          errs_at_reset = 0;
  int          exp_errs = 0;
  logic [31:0] last_sof_iq = '0;
  logic [31:0] ant1_iq = '0;
  bit          want_ant1 = 0;
  exp_t        expq[$];
  exp_t        e_mon;
  vec_t        tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  function automatic int gw(input logic [1:0] ms);
    return ((ms == 2'd1) || (ms == 2'd2)) ? 32 : 16;
  endfunction

  function automatic logic [31:0] exp_cnt(input int n);
`ifdef LTE_DW_DFE_DEFRAMER_STAT_EN
    return (n > 15) ? 32'd15 : 32'(n);
`else
    return (n > 15) ? 32'd0 : 32'd0 & 32'(n);
`endif
  endfunction

  always @(negedge sys_clk_491p52) begin
    if (!sys_rst_491p52) begin
      if (bus.o_err_pulse) err_seen++;
      if (bus.o_vld) begin
        vld_seen++;
        if (bus.o_sof) begin
          sof_seen++;
          last_sof_iq = bus.o_iq;
          want_ant1 = 1;
        end
        if (want_ant1 && (bus.o_ant_idx == 3'd1)) begin
          ant1_iq = bus.o_iq;
          want_ant1 = 0;
        end
        if (expq.size() == 0) begin
          chk("unexpected_vld", 32'(bus.o_vld), 32'd0);
        end else begin
          e_mon = expq.pop_front();
          chk("iq", bus.o_iq, e_mon.iq);
          chk("ant_idx", 32'(bus.o_ant_idx), 32'(e_mon.ant));
          chk("sof", 32'(bus.o_sof), 32'(e_mon.sof));
        end
      end else begin
        chk("sof_without_vld", 32'(bus.o_sof), 32'd0);
      end
    end
  end

  task automatic step(input logic f, input logic x, input logic [15:0] d);
    bus.i_fram = f;
    bus.i_xant = x;
    bus.i_data = d;
    @(posedge sys_clk_491p52);
    #1;
  endtask

  task automatic settle();
    @(negedge sys_clk_491p52);
    #1;
  endtask

  // Caller is just past a negedge; outputs must clear while reset is held.
  task automatic do_reset();
    chk("queue_empty", 32'(expq.size()), 32'd0);
    sys_rst_491p52 = 1'b1;
    bus.i_fram = 1'b0;
    bus.i_xant = 1'b0;
    bus.i_data = 16'd0;
    bus.i_mod_sel = 2'd0;
    #1;
    chk("rst_vld", 32'(bus.o_vld), 32'd0);
    chk("rst_sof", 32'(bus.o_sof), 32'd0);
    chk("rst_ant_idx", 32'(bus.o_ant_idx), 32'd0);
    chk("rst_iq", bus.o_iq, 32'd0);
    chk("rst_locked", 32'(bus.o_locked), 32'd0);
    chk("rst_err_pulse", 32'(bus.o_err_pulse), 32'd0);
    chk("rst_err_cnt", 32'(bus.o_err_cnt), 32'd0);
    @(posedge sys_clk_491p52);
    #1;
    sys_rst_491p52 = 1'b0;
    exp_errs = 0;
    errs_at_reset = err_seen;
  endtask

  // Sends the first nwords of a frame; pairs broken by an injected early xant are not expected.
  task automatic send_frame(input logic [1:0] ms, input int nwords, input bit ramp,
                            input logic [15:0] base, input int bad_xant, input bit resync);
    int          g;
    logic [15:0] d;
    logic [15:0] prev;
    exp_t        e;
    g = gw(ms);
    prev = 16'd0;
    bus.i_mod_sel = ms;
    for (int i = 0; i < nwords; i++) begin
      int w;
      int a;
      w = i % g;
      a = i / g;
      d = ramp ? 16'(32'(base) + i) : 16'($urandom);
      if (((w % 2) == 1) && (i != bad_xant)) begin
        e.iq  = {prev, d};
        e.ant = 3'(a);
        e.sof = (i == 1);
        expq.push_back(e);
      end
      step(i == 0, (w == g - 1) || (i == bad_xant), d);
      if (i == 0) begin
        if (resync) begin
          chk("resync_err_pulse", 32'(bus.o_err_pulse), 32'd1);
          chk("resync_locked", 32'(bus.o_locked), 32'd1);
        end
        bus.i_mod_sel = 2'($urandom);
      end
      prev = d;
    end
  endtask

  task automatic chk_errs(input string name);
    chk({name, "_pulses"}, 32'(err_seen - errs_at_reset), 32'(exp_errs));
    chk({name, "_err_cnt"}, 32'(bus.o_err_cnt), exp_cnt(exp_errs));
  endtask

  initial begin
    int v0;
    int s0;
    logic [1:0] ms;

    tbl[0] = '{ms: 2'd3, base: 16'h0000, n_vld: 64,  first_iq: 32'h0000_0001, ant1_iq: 32'h0010_0011};
    tbl[1] = '{ms: 2'd1, base: 16'h0000, n_vld: 128, first_iq: 32'h0000_0001, ant1_iq: 32'h0020_0021};
    tbl[2] = '{ms: 2'd2, base: 16'h0100, n_vld: 128, first_iq: 32'h0100_0101, ant1_iq: 32'h0120_0121};
    tbl[3] = '{ms: 2'd0, base: 16'h8000, n_vld: 64,  first_iq: 32'h8000_8001, ant1_iq: 32'h8010_8011};

    bus.i_mod_sel = 2'd0;
    bus.i_fram = 1'b0;
    bus.i_xant = 1'b0;
    bus.i_data = 16'd0;
    settle();
    do_reset();

    for (int t = 0; t < 4; t++) begin
      v0 = vld_seen;
      s0 = sof_seen;
      send_frame(tbl[t].ms, 8 * gw(tbl[t].ms), 1, tbl[t].base, -1, 0);
      settle();
      chk("tbl_vld_count", 32'(vld_seen - v0), 32'(tbl[t].n_vld));
      chk("tbl_sof_count", 32'(sof_seen - s0), 32'd1);
      chk("tbl_first_iq", last_sof_iq, tbl[t].first_iq);
      chk("tbl_ant1_iq", ant1_iq, tbl[t].ant1_iq);
      chk("tbl_locked", 32'(bus.o_locked), 32'd1);
      chk_errs("tbl");
      do_reset();
    end

    v0 = vld_seen;
    s0 = sof_seen;
    for (int f = 0; f < 3; f++) send_frame(2'd1, 256, 1, 16'(f * 256), -1, 0);
    settle();
    chk("b2b_vld_count", 32'(vld_seen - v0), 32'd384);
    chk("b2b_sof_count", 32'(sof_seen - s0), 32'd3);
    chk_errs("b2b");
    do_reset();

    for (int f = 0; f < 6; f++) begin
      ms = 2'($urandom_range(0, 3));
      send_frame(ms, 8 * gw(ms), 0, 16'd0, -1, 0);
    end
    settle();
    chk("rand_locked", 32'(bus.o_locked), 32'd1);
    chk_errs("rand");
    do_reset();

    send_frame(2'd3, 42, 0, 16'd0, 41, 0);
    exp_errs++;
    chk("early_xant_pulse", 32'(bus.o_err_pulse), 32'd1);
    chk("early_xant_locked", 32'(bus.o_locked), 32'd0);
    for (int k = 0; k < 6; k++) step(1'b0, 1'($urandom), 16'($urandom));
    chk("early_xant_hunt", 32'(bus.o_locked), 32'd0);
    chk_errs("early_xant");

    send_frame(2'd1, 256, 1, 16'h1000, -1, 0);
    send_frame(2'd1, 4 * 32 + 6, 1, 16'h2000, -1, 0);
    exp_errs++;
    send_frame(2'd1, 256, 1, 16'h3000, -1, 1);

    step(1'b0, 1'b0, 16'h5555);
    exp_errs++;
    chk("miss_fram_pulse", 32'(bus.o_err_pulse), 32'd1);
    chk("miss_fram_locked", 32'(bus.o_locked), 32'd0);
    send_frame(2'd2, 51, 0, 16'd0, -1, 0);
    settle();
    chk("partial_locked", 32'(bus.o_locked), 32'd1);
    chk_errs("miss_fram");
    do_reset();
    send_frame(2'd3, 128, 1, 16'h4000, -1, 0);
    settle();
    chk("reacq_locked", 32'(bus.o_locked), 32'd1);
    chk_errs("reacq");
    do_reset();

    for (int k = 0; k < 20; k++) begin
      step(1'b1, 1'b0, 16'($urandom));
      step(1'b0, 1'b1, 16'($urandom));
      exp_errs++;
    end
    settle();
    chk_errs("sat");
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
